// File: rtl/full_connect2_argmax_if.sv
// Bus bundle between the classifier output layer and its environment (activations, ROM, MultAdder, result).
// The slave modport is the full_connect2_argmax side; master is the surrounding datapath.
interface full_connect2_argmax_if #(
   parameter int BIT   = 8,
   parameter int ACC_W = 2*BIT-1
);
   logic                    ena;
   logic [128*BIT-1:0]      data_from_fc1;
   logic [128*BIT-1:0]      data_from_rom;
   logic signed [ACC_W-1:0] data_from_MultAdder;
   logic                    overflow_from_MultAdder;
   logic [10:0]             addr_to_rom;
   logic [128*BIT-1:0]      opr1_to_MultAdder;
   logic [128*BIT-1:0]      opr2_to_MultAdder;
   logic [3:0]              digit;
   logic                    done;
   logic                    overflow;

   modport slave (
      input  ena, data_from_fc1, data_from_rom, data_from_MultAdder, overflow_from_MultAdder,
      output addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder, digit, done, overflow
   );

   modport master (
      output ena, data_from_fc1, data_from_rom, data_from_MultAdder, overflow_from_MultAdder,
      input  addr_to_rom, opr1_to_MultAdder, opr2_to_MultAdder, digit, done, overflow
   );
endinterface

// File: rtl/full_connect2_argmax.sv
// Output layer: 10 scores = dot(W[row], act) + bias[row] via shared MultAdder, then argmax digit.
// Define FC2_SATURATE_EN to clamp the bias add on overflow instead of wrapping.
module full_connect2_argmax #(
   parameter int         BIT         = 8,
   parameter int         ACC_W       = 2*BIT-1,
   parameter logic [10:0] WEIGHT_BASE = 11'h480,
   parameter logic [10:0] BIAS_BASE   = 11'h48A
) (
   input  logic                  clk,
   input  logic                  iRst_n,
   full_connect2_argmax_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ASK_B, S_GET_B, S_ASK_W, S_LOAD, S_ACC, S_CMP, S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [10:0]             addr_q, addr_d;
   logic [128*BIT-1:0]      opr1_q, opr1_d;
   logic [128*BIT-1:0]      opr2_q, opr2_d;
   logic [10*BIT-1:0]       bias_q, bias_d;
   logic [3:0]              row_q, row_d;
   logic signed [ACC_W-1:0] score_q, score_d;
   logic signed [ACC_W-1:0] best_q, best_d;
   logic [3:0]              win_q, win_d;
   logic [3:0]              digit_q, digit_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;

   logic signed [BIT-1:0]   bias_lane;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    add_ovf;
   logic                    take;

   assign bias_lane = bias_q[BIT*int'(row_q) +: BIT];
   assign bias_ext  = {{(ACC_W-BIT){bias_lane[BIT-1]}}, bias_lane};
   assign sum       = bus.data_from_MultAdder + bias_ext;
   assign add_ovf   = (bus.data_from_MultAdder[ACC_W-1] == bias_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != bias_ext[ACC_W-1]);
   assign take      = (row_q == 4'd0) || (score_q > best_q);

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         opr1_q  <= '0;
         opr2_q  <= '0;
         bias_q  <= '0;
         row_q   <= '0;
         score_q <= '0;
         best_q  <= '0;
         win_q   <= '0;
         digit_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         opr1_q  <= opr1_d;
         opr2_q  <= opr2_d;
         bias_q  <= bias_d;
         row_q   <= row_d;
         score_q <= score_d;
         best_q  <= best_d;
         win_q   <= win_d;
         digit_q <= digit_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      opr1_d  = opr1_q;
      opr2_d  = opr2_q;
      bias_d  = bias_q;
      row_d   = row_q;
      score_d = score_q;
      best_d  = best_q;
      win_d   = win_q;
      digit_d = digit_q;
      done_d  = done_q;
      ovf_d   = ovf_q;

      // Dropping ena anywhere past IDLE aborts without touching digit or the running scores.
      if (state_q != S_IDLE && !bus.ena) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.ena) begin
                  ovf_d   = 1'b0;
                  done_d  = 1'b0;
                  row_d   = '0;
                  state_d = S_ASK_B;
               end
            end
            S_ASK_B: begin
               addr_d  = BIAS_BASE;
               state_d = S_GET_B;
            end
            S_GET_B: begin
               bias_d  = bus.data_from_rom[10*BIT-1:0];
               state_d = S_ASK_W;
            end
            S_ASK_W: begin
               addr_d  = WEIGHT_BASE + 11'(row_q);
               state_d = S_LOAD;
            end
            S_LOAD: begin
               opr1_d  = bus.data_from_fc1;
               opr2_d  = bus.data_from_rom;
               state_d = S_ACC;
            end
            S_ACC: begin
`ifdef FC2_SATURATE_EN
               if (add_ovf)
                  score_d = bias_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
               else
                  score_d = sum;
`else
               score_d = sum;
`endif
               ovf_d   = ovf_q | bus.overflow_from_MultAdder | add_ovf;
               state_d = S_CMP;
            end
            S_CMP: begin
               if (take) begin
                  best_d = score_q;
                  win_d  = row_q;
               end
               if (row_q == 4'd9) begin
                  digit_d = take ? row_q : win_q;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  row_d   = row_q + 4'd1;
                  state_d = S_ASK_W;
               end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.addr_to_rom       = addr_q;
   assign bus.opr1_to_MultAdder = opr1_q;
   assign bus.opr2_to_MultAdder = opr2_q;
   assign bus.digit             = digit_q;
   assign bus.done              = done_q;
   assign bus.overflow          = ovf_q;

endmodule
